// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Byte-addressed load/store front end for a 32-bit EAB data RAM,
//            read-modify-write for sub-word stores. Optional misalignment
//            trap via DATA_MEM_CTRL_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_data,
    output logic                  ram_we,
    input  logic [31:0]           ram_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH+1:0] addr_r;
    logic [1:0]            size_r;
    logic                  we_r;
    logic                  uns_r;
    logic [15:0]           wdata_r;

    logic        accept;
    logic        req_err;
    logic        word_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept && req_err) begin
            rsp_err <= 1'b1;
        end else if ((accept && word_store) || state == RD_DATA) begin
            rsp_err <= 1'b0;
        end
    end
`else
    assign req_err = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    // size[1] covers word and (untrapped) reserved size, both handled as word
    assign word_store = req_we && req_size[1] && !req_err;

    always_comb begin
        byte_sel = ram_q[{addr_r[1:0], 3'b000} +: 8];
        half_sel = ram_q[{addr_r[1], 4'b0000} +: 16];
        case (size_r)
            2'b00:   load_data = {{24{byte_sel[7] & ~uns_r}}, byte_sel};
            2'b01:   load_data = {{16{half_sel[15] & ~uns_r}}, half_sel};
            default: load_data = ram_q;
        endcase
        merged = ram_q;
        if (size_r == 2'b00) begin
            merged[{addr_r[1:0], 3'b000} +: 8] = wdata_r[7:0];
        end else begin
            merged[{addr_r[1], 4'b0000} +: 16] = wdata_r;
        end
    end

    always_comb begin
        state_next  = state;
        ram_address = req_addr[ADDR_WIDTH+1:2];
        ram_data    = req_wdata;
        ram_we      = 1'b0;
        case (state)
            IDLE: begin
                ram_we = req_valid && word_store;
                if (accept && !req_err && !word_store) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                ram_address = addr_r[ADDR_WIDTH+1:2];
                state_next  = RD_DATA;
            end
            RD_DATA: begin
                ram_address = addr_r[ADDR_WIDTH+1:2];
                ram_data    = merged;
                ram_we      = we_r;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            state     <= state_next;
            rsp_valid <= 1'b0;
            if (accept && (req_err || word_store)) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= 32'd0;
            end
            if (state == RD_DATA) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= we_r ? 32'd0 : load_data;
            end
        end
    end

    // Request capture needs no reset: only consumed after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r  <= req_addr[ADDR_WIDTH+1:0];
            size_r  <= req_size;
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata[15:0];
        end
    end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

- Sits between the CPU load/store unit and the 32-bit data RAM built from `lpm_ram_dq` EABs.
- Converts byte-addressed load/store requests into word-addressed RAM accesses, including byte and halfword sizes.
- Performs read-modify-write for sub-word stores, because the EABs have no byte enables.
- Returns loads with sign or zero extension, and returns a one-cycle response for every request.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: RAM word-address width. The RAM holds 2**ADDR_WIDTH 32-bit words.

Ports:
- `clk` input, 1 bit: single clock. The RAM's `inclock` and `outclock` are both tied to `clk`.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: controller can accept a request. It is high only in IDLE.
- `req_we` input, 1 bit: 1 = store, 0 = load.
- `req_addr` input, 32 bits: byte address. Bits `[ADDR_WIDTH+1:2]` select the word; higher bits are ignored.
- `req_size` input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned` input, 1 bit: zero-extend loads (lbu/lhu).
- `req_wdata` input, 32 bits: store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` output, 1 bit: one-cycle pulse marking completion. There is no back-pressure; the consumer must take the response.
- `rsp_rdata` output, 32 bits: load result. It is 0 for stores.
- `rsp_err` output, 1 bit: misaligned or reserved-size access. Only driven when the configuration macro is defined.
- `ram_address` output, ADDR_WIDTH bits: to RAM `address`.
- `ram_data` output, 32 bits: to RAM `data`.
- `ram_we` output, 1 bit: to RAM `we`.
- `ram_q` input, 32 bits: from RAM `q`. It is valid two `clk` edges after the address is sampled.

## Operation
- Accept occurs on a rising edge where `req_valid && req_ready`. The request is latched into `addr_r`, `size_r`, `we_r`, `uns_r` and `wdata_r`.
- Lanes are little-endian: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- States:
  - IDLE: `ram_address` = `req_addr[ADDR_WIDTH+1:2]`, driven combinationally so the RAM samples it on the accept edge. Transitions:
    - Aligned word store: `ram_we` = `req_valid`, `ram_data` = `req_wdata`. The write completes on the accept edge; set `rsp_valid`; stay in IDLE.
    - Load or sub-word store: go to RD_WAIT.
  - RD_WAIT: `ram_address` = `addr_r` word; `ram_we` = 0; go to RD_DATA.
  - RD_DATA: `ram_q` holds the word.
    - Load: register the extracted lane into `rsp_rdata` and set `rsp_valid`.
    - Sub-word store: `ram_we` = 1, `ram_data` = `ram_q` with the addressed lane replaced by `wdata_r[7:0]` or `wdata_r[15:0]`; set `rsp_valid`.
    - Either case: go to IDLE.
- Extension:
  - Byte: bit 7 of the lane is replicated into [31:8] unless `uns_r`.
  - Half: bit 15 of the lane is replicated into [31:16] unless `uns_r`.
  - Word: passed through.
- `rsp_valid` is asserted for exactly one cycle per accepted request. `rsp_rdata` and `rsp_err` hold their values until the next response.

## Timing
- Reset values: state = IDLE, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0. With `req_valid` = 0, `ram_we` = 0.
- Word store: `rsp_valid` is high in the cycle after the accept edge (latency 1).
- Load or sub-word store: accept at edge E0, RD_WAIT after E0, RD_DATA after E1. For sub-word stores the RAM write occurs at E2. `rsp_valid` is high in the cycle after E2 (latency 3).
- `req_ready` = 0 in RD_WAIT and RD_DATA. It is 1 during the `rsp_valid` cycle, so back-to-back requests issue with no bubble.
- Store followed by a load of the same word: the store completes before the load is accepted, so the load returns the new data.
- Reset asserted mid-operation: state returns to IDLE immediately and no response is produced. A sub-word store in RD_WAIT is dropped with no RAM write; in RD_DATA, `ram_we` drops asynchronously.

## Configuration
- `DATA_MEM_CTRL_MISALIGN_TRAP_EN` defined:
  - These requests are errors: half with `addr[0]`=1, word with `addr[1:0]`≠0, and any request with size 11.
  - An erroring request gets no RAM access (`ram_we` = 0) and stays in IDLE.
  - The next cycle shows `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0.
  - Good requests clear `rsp_err`.
- Undefined:
  - `rsp_err` is tied to 0.
  - Half ignores `addr[0]`; word ignores `addr[1:0]`; size 11 is treated as word.

## Test plan
- Word store 0xDEADBEEF at 0x10, then lw 0x10 → rsp_valid 1 cycle after the store accept; load rsp_rdata = 0xDEADBEEF, 3 cycles after accept.
- Word 0x10 = 0x11223344, sb 0xAA at 0x12 → RAM write 0x11AA3344 at E2; lw 0x10 returns 0x11AA3344.
- Word 0x20 = 0x80FF7F01 → lb 0x23 = 0xFFFFFF80; lbu 0x23 = 0x00000080; lh 0x20 = 0x00007F01; lh 0x22 = 0xFFFF80FF.
- req_valid held high with 4 alternating lw/sw → req_ready low only in RD_WAIT/RD_DATA; exactly 4 rsp_valid pulses; no lost requests.
- rst_n pulled low in RD_WAIT of sb 0x55 to 0x31 → outputs 0 immediately; word 0x30 unchanged; no rsp_valid.
- With the macro, lw 0x22 → rsp_err = 1, rsp_rdata = 0, ram_we never asserted. Without it, the same request returns word 0x20.
